// File: rtl/activation_cache.sv
// Activation history buffer: stores accepted vectors in a circular buffer and
// emits four dilated taps (oldest to newest) one cycle after each accepted sample.
module activation_cache #(
  parameter int unsigned W        = 16,
  parameter int unsigned D        = 16,
  parameter int unsigned DILATION = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic signed [D*W-1:0] packed_in,
  input  logic                  in_v,
  output logic                  in_ready,
  output logic signed [D*W-1:0] packed_a0,
  output logic signed [D*W-1:0] packed_a1,
  output logic signed [D*W-1:0] packed_a2,
  output logic signed [D*W-1:0] packed_a3,
  output logic                  out_v,
  output logic                  primed
);

  localparam int unsigned DEPTH = 3 * DILATION + 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW    = AW + 1;
  localparam int unsigned VW    = D * W;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [VW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [FW-1:0]   r_fill;
  logic            r_primed;
  logic            r_out_v;
  logic [VW-1:0]   r_a0;
  logic [VW-1:0]   r_a1;
  logic [VW-1:0]   r_a2;
  logic [VW-1:0]   r_a3;

  logic [AW-1:0]   w_newest;
  logic [AW-1:0]   w_next_ptr;
  logic [AW-1:0]   w_idx [4];

  // Index of the slot 'back' samples older than 'newest', modulo DEPTH.
  function automatic logic [AW-1:0] tap_idx(input logic [AW-1:0] newest,
                                            input int unsigned back);
    logic [FW-1:0] s;
    s = {1'b0, newest} + FW'(DEPTH) - FW'(back);
    if (s >= FW'(DEPTH)) s = s - FW'(DEPTH);
    return s[AW-1:0];
  endfunction

  // Pointer arithmetic with explicit wrap for non-power-of-two depths.
  always_comb begin
    w_newest   = (r_wr_ptr == '0) ? AW'(DEPTH - 1) : r_wr_ptr - AW'(1);
    w_next_ptr = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = tap_idx(w_newest, (3 - k) * DILATION);
    end
  end

  // Accept/emit FSM, history storage and registered taps; rst and clear both flush.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
      r_out_v  <= 1'b0;
      r_a0     <= '0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_a3     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_out_v <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_v) begin
            r_mem[r_wr_ptr] <= packed_in;
            r_wr_ptr        <= w_next_ptr;
            if (r_fill != FW'(DEPTH)) r_fill <= r_fill + FW'(1);
            if (r_fill >= FW'(DEPTH - 1)) r_primed <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          r_a0    <= r_mem[w_idx[0]];
          r_a1    <= r_mem[w_idx[1]];
          r_a2    <= r_mem[w_idx[2]];
          r_a3    <= r_mem[w_idx[3]];
          r_out_v <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_v     = r_out_v;
  assign primed    = r_primed;
  assign packed_a0 = r_a0;
  assign packed_a1 = r_a1;
  assign packed_a2 = r_a2;
  assign packed_a3 = r_a3;

endmodule

// File: tb/tb_activation_cache.sv
// Bench for activation_cache: one instance with DILATION=1 and one with
// DILATION=2 share the stimulus; a history-queue model predicts both.
module tb_activation_cache;

  localparam int W = 16;
  localparam int D = 16;
  typedef logic [D*W-1:0] vec_t;

  logic clk, rst, clear, in_v;
  vec_t packed_in;

  logic rdy1, ov1, pr1, rdy2, ov2, pr2;
  logic signed [D*W-1:0] a0_1, a1_1, a2_1, a3_1;
  logic signed [D*W-1:0] a0_2, a1_2, a2_2, a3_2;

  activation_cache #(.W(W), .D(D), .DILATION(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .packed_in(packed_in), .in_v(in_v),
    .in_ready(rdy1), .packed_a0(a0_1), .packed_a1(a1_1), .packed_a2(a2_1),
    .packed_a3(a3_1), .out_v(ov1), .primed(pr1)
  );

  activation_cache #(.W(W), .D(D), .DILATION(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .packed_in(packed_in), .in_v(in_v),
    .in_ready(rdy2), .packed_a0(a0_2), .packed_a1(a1_2), .packed_a2(a2_2),
    .packed_a3(a3_2), .out_v(ov2), .primed(pr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History of accepted samples since last reset/clear, newest at the back.
  vec_t q[$];
  int   n_acc  = 0;
  bit   m_busy = 1'b0;
  bit   m_outv = 1'b0;
  vec_t e1 [4];
  vec_t e2 [4];

  function automatic vec_t tap_of(input int back);
    int i;
    i = int'(q.size()) - 1 - back;
    if (i < 0) return '0;
    return q[i];
  endfunction

  task automatic model_flush();
    q.delete();
    n_acc  = 0;
    m_busy = 1'b0;
    m_outv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e1[k] = '0;
      e2[k] = '0;
    end
  endtask

  task automatic model_step();
    if (rst || clear) begin
      model_flush();
    end else if (m_busy) begin
      m_busy = 1'b0;
      m_outv = 1'b1;
      for (int k = 0; k < 4; k++) begin
        e1[k] = tap_of((3 - k) * 1);
        e2[k] = tap_of((3 - k) * 2);
      end
    end else begin
      m_outv = 1'b0;
      if (in_v) begin
        q.push_back(packed_in);
        if (q.size() > 32) void'(q.pop_front());
        n_acc++;
        m_busy = 1'b1;
      end
    end
  endtask

  initial begin
    model_flush();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("rdy1", vec_t'(rdy1), vec_t'(!m_busy));
        chk("rdy2", vec_t'(rdy2), vec_t'(!m_busy));
        chk("outv1", vec_t'(ov1), vec_t'(m_outv));
        chk("outv2", vec_t'(ov2), vec_t'(m_outv));
        chk("primed1", vec_t'(pr1), vec_t'(n_acc >= 4));
        chk("primed2", vec_t'(pr2), vec_t'(n_acc >= 7));
        chk("d1_a0", a0_1, e1[0]);
        chk("d1_a1", a1_1, e1[1]);
        chk("d1_a2", a2_1, e1[2]);
        chk("d1_a3", a3_1, e1[3]);
        chk("d2_a0", a0_2, e2[0]);
        chk("d2_a1", a1_2, e2[1]);
        chk("d2_a2", a2_2, e2[2]);
        chk("d2_a3", a3_2, e2[3]);
        if (ov2) pulse_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic vec_t rep(input logic [15:0] k);
    vec_t v;
    v = '0;
    for (int j = 0; j < D; j++) v[(D-j)*W-1 -: W] = k;
    return v;
  endfunction

  // Apply inputs now; return at the next falling edge with results visible.
  task automatic drive(input bit v, input vec_t d, input bit c, input bit r);
    in_v      = v;
    packed_in = d;
    clear     = c;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic feed(input vec_t d);
    drive(1'b1, d, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t sv;
    logic [15:0] top, bot;
    int p0;

    in_v = 1'b0; clear = 1'b0; rst = 1'b1; packed_in = '0;
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset state and ready in the first cycle after release
    chk("lit_reset_ready", vec_t'(rdy2), vec_t'(1));
    chk("lit_reset_outv", vec_t'(ov2), '0);
    chk("lit_reset_primed", vec_t'(pr2), '0);
    chk("lit_reset_a3", a3_2, '0);

    // Zero padding, DILATION=1
    p0 = pulse_cnt;
    feed(rep(16'h0100));
    chk("lit_pad_outv", vec_t'(ov1), vec_t'(1));
    chk("lit_pad_a3", a3_1, rep(16'h0100));
    chk("lit_pad_a2", a2_1, '0);
    chk("lit_pad_a1", a1_1, '0);
    chk("lit_pad_a0", a0_1, '0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lit_pad_pulses", vec_t'(pulse_cnt - p0), vec_t'(1));

    // Priming and taps, DILATION=2
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int s = 1; s <= 7; s++) begin
      feed(rep(16'(s)));
      chk($sformatf("lit_primed_s%0d", s), vec_t'(pr2), vec_t'(s == 7));
    end
    chk("lit_prime_a0", a0_2, rep(16'd1));
    chk("lit_prime_a1", a1_2, rep(16'd3));
    chk("lit_prime_a2", a2_2, rep(16'd5));
    chk("lit_prime_a3", a3_2, rep(16'd7));

    // Wrap-around with continuous feed
    drive(1'b0, '0, 1'b0, 1'b1);
    p0 = pulse_cnt;
    for (int s = 1; s <= 20; s++) feed(rep(16'(s)));
    chk("lit_wrap_a0", a0_2, rep(16'd14));
    chk("lit_wrap_a1", a1_2, rep(16'd16));
    chk("lit_wrap_a2", a2_2, rep(16'd18));
    chk("lit_wrap_a3", a3_2, rep(16'd20));
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lit_wrap_pulses", vec_t'(pulse_cnt - p0), vec_t'(20));

    // Backpressure: in_v held with new data every cycle
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) drive(1'b1, rep(16'(100 + i)), 1'b0, 1'b0);
    chk("lit_bp_a3_d2", a3_2, rep(16'd106));
    chk("lit_bp_a2_d1", a2_1, rep(16'd104));
    chk("lit_bp_a1_d1", a1_1, rep(16'd102));
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lit_bp_pulses", vec_t'(pulse_cnt - p0), vec_t'(4));

    // Clear with concurrent input while primed
    drive(1'b1, rep(16'h1234), 1'b1, 1'b0);
    chk("lit_clr_primed", vec_t'(pr2), '0);
    chk("lit_clr_a3", a3_2, '0);
    feed(rep(16'h7FFF));
    chk("lit_clr_new_a3", a3_2, rep(16'h7FFF));
    chk("lit_clr_new_a2", a2_2, '0);
    chk("lit_clr_new_a0", a0_2, '0);
    chk("lit_clr_new_primed", vec_t'(pr2), '0);

    // Signs and packing: element j = -(j+1)
    for (int j = 0; j < D; j++) sv[(D-j)*W-1 -: W] = 16'(-(j + 1));
    feed(sv);
    chk("lit_sign_a3", a3_2, sv);
    top = a3_2[D*W-1 -: W];
    bot = a3_2[W-1:0];
    chk("lit_sign_msb_elem", vec_t'(top), vec_t'(16'hFFFF));
    chk("lit_sign_lsb_elem", vec_t'(bot), vec_t'(16'hFFF0));

    // Clear during EMIT suppresses the pulse
    p0 = pulse_cnt;
    drive(1'b1, rep(16'd5), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lit_clr_emit_pulses", vec_t'(pulse_cnt - p0), '0);

    // Reset during EMIT suppresses the pulse
    feed(rep(16'd8));
    p0 = pulse_cnt;
    drive(1'b1, rep(16'd9), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("lit_rst_emit_pulses", vec_t'(pulse_cnt - p0), '0);
    chk("lit_rst_emit_ready", vec_t'(rdy1), vec_t'(1));
    chk("lit_rst_emit_a3", a3_1, '0);

    drive(1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
